// File: rtl/coh_noc_pkg.sv
// coh_noc_pkg: shared flit format, VC identifiers and NoC defaults
package coh_noc_pkg;

    localparam int NUM_VCS_DEFAULT = 4;

    typedef logic [1:0] vc_id_t;

    localparam vc_id_t VC_REQ = 2'd0;
    localparam vc_id_t VC_RSP = 2'd1;
    localparam vc_id_t VC_DAT = 2'd2;
    localparam vc_id_t VC_SNP = 2'd3;

    typedef struct packed {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [47:0] payload;
    } flit_s;

    typedef union packed {
        flit_s       f;
        logic [63:0] raw;
    } flit_u;

endpackage

// File: rtl/vc_credit_tx_rr_arbiter.sv
// rr_arbiter: round-robin one-hot arbiter whose priority restarts after the last winner
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    int            w_idx;

    // Scan downward so the requester closest to the pointer overwrites the others
    always_comb begin
        grant      = '0;
        w_next_ptr = r_ptr;
        w_idx      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (req[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
                w_next_ptr   = PW'((w_idx + 1) % N);
            end
        end
    end

    // Pointer holds the first VC to consider next; it only moves when something is granted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_ptr <= '0;
        else if (advance) r_ptr <= w_next_ptr;
    end

endmodule

// File: rtl/vc_credit_tx.sv
// vc_credit_tx: credit-based per-VC link transmitter with round-robin VC arbitration
module vc_credit_tx
    import coh_noc_pkg::*;
#(
    parameter int BUFFER_DEPTH = 16,
    parameter int NUM_VCS      = NUM_VCS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_VCS-1:0] in_valid,
    input  flit_u              in_flit [0:NUM_VCS-1],
    output logic [NUM_VCS-1:0] in_ready,
    output logic               link_valid,
    output vc_id_t             link_vc_id,
    output flit_u              link_flit,
    input  logic               crd_valid,
    input  vc_id_t             crd_vc_id,
    output logic [7:0]         credit_count [0:NUM_VCS-1],
    output logic               crd_err
);

    localparam logic [7:0] FULL = 8'(BUFFER_DEPTH);

    logic [7:0]         r_cnt [0:NUM_VCS-1];
    logic               r_link_valid;
    vc_id_t             r_link_vc;
    flit_u              r_link_flit;
    logic               r_err;
    logic [NUM_VCS-1:0] w_elig;
    logic [NUM_VCS-1:0] w_full;
    logic [NUM_VCS-1:0] w_ret;
    logic [NUM_VCS-1:0] w_arb_grant;
    logic [NUM_VCS-1:0] w_grant;
    vc_id_t             w_gvc;
    flit_u              w_gflit;
    logic               w_bad;
    logic               w_ovf;

    // Eligibility uses registered credits only, so a returned credit is spendable next cycle
    always_comb begin
        w_elig = '0;
        w_full = '0;
        w_ret  = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            w_elig[i] = in_valid[i] && (r_cnt[i] != 8'd0);
            w_full[i] = r_cnt[i] == FULL;
            w_ret[i]  = crd_valid && (crd_vc_id == vc_id_t'(i));
        end
    end

    rr_arbiter #(.N(NUM_VCS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_elig),
        .advance (|w_grant),
        .grant   (w_arb_grant)
    );

    assign w_grant  = rst_n ? w_arb_grant : '0;
    assign in_ready = w_grant;
    assign w_bad    = crd_valid && !(|w_ret);
    assign w_ovf    = |(w_ret & ~w_grant & w_full);

    // Mux the granted VC's flit and id toward the link register
    always_comb begin
        w_gvc   = VC_REQ;
        w_gflit = '0;
        for (int i = 0; i < NUM_VCS; i++) begin
            if (w_grant[i]) begin
                w_gvc   = vc_id_t'(i);
                w_gflit = in_flit[i];
            end
        end
    end

    // Per-VC credit counters: spend on grant, refill on return, saturate at full depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VCS; i++) r_cnt[i] <= FULL;
        end else begin
            for (int i = 0; i < NUM_VCS; i++) begin
                if (w_grant[i] && !w_ret[i]) r_cnt[i] <= r_cnt[i] - 8'd1;
                else if (w_ret[i] && !w_grant[i] && !w_full[i]) r_cnt[i] <= r_cnt[i] + 8'd1;
            end
        end
    end

    // Sticky error on a credit for an unknown VC or one beyond the buffer depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err <= 1'b0;
        else r_err <= r_err | w_bad | w_ovf;
    end

    // Link register: one flit per cycle, payload and VC held while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link_valid <= 1'b0;
            r_link_vc    <= VC_REQ;
            r_link_flit  <= '0;
        end else begin
            r_link_valid <= |w_grant;
            if (|w_grant) begin
                r_link_vc   <= w_gvc;
                r_link_flit <= w_gflit;
            end
        end
    end

    assign credit_count = r_cnt;
    assign link_valid   = r_link_valid;
    assign link_vc_id   = r_link_vc;
    assign link_flit    = r_link_flit;
    assign crd_err      = r_err;

endmodule

// File: doc/vc_credit_tx.md
Name: vc_credit_tx

Overview:
Output-port transmitter at the far end of a link whose receiver holds per-VC input buffers (REQ/RSP/DAT/SNP).
- Keeps one credit counter per VC that mirrors the free slots in the downstream buffer.
- Each cycle, round-robin arbitrates among upstream VC sources that have a flit and at least one credit.
- Drives one registered flit per cycle onto the link, tagged with its VC ID.
- Credits come back from the receiver as each flit is read out of its buffer.

Parameters:
- BUFFER_DEPTH, 16, downstream per-VC buffer depth; also the credit reset value (must be ≤255).
- NUM_VCS, 4, number of virtual channels (REQ=0, RSP=1, DAT=2, SNP=3).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  NUM_VCS  per-VC upstream flit valid
- in_flit  input  flit_u [0:NUM_VCS-1]  per-VC upstream flit
- in_ready  output  NUM_VCS  per-VC accept; one-hot or zero
- link_valid  output  1  flit on link this cycle
- link_vc_id  output  2  VC of link flit
- link_flit  output  flit_u  link flit
- crd_valid  input  1  one credit returned this cycle
- crd_vc_id  input  2  VC of returned credit
- credit_count  output  8 [0:NUM_VCS-1]  current credits per VC
- crd_err  output  1  sticky protocol error flag

Behaviour:
- Reset is asynchronous and active-low.
  - credit_count[i] = BUFFER_DEPTH for every VC.
  - link_valid = 0, link_vc_id = 0, link_flit = '0.
  - crd_err = 0; round-robin pointer = 0.
  - in_ready = 0 while rst_n is low.
- Eligibility: eligible[i] = in_valid[i] && credit_count[i] != 0.
  - Uses only the registered count, so a credit returned in cycle N cannot be spent until cycle N+1.
- Arbitration: round-robin over eligible, starting at the VC after the last granted one.
  - The pointer advances only on a grant.
  - With a single eligible VC, that VC is granted every cycle.
- in_ready = grant, combinational from in_valid and registered state.
  - Upstream transfer occurs when in_valid[i] && in_ready[i].
  - in_ready[i] never depends on in_flit.
- Latency: a flit accepted in cycle N appears on link_valid/link_vc_id/link_flit in cycle N+1.
  - link_valid = 0 in any cycle following a no-grant cycle.
  - link_flit holds its last value when link_valid = 0.
- The link has no backpressure; credits are the only flow control.
- Credit update for each VC i, per cycle:
  - consume = grant[i]; ret = crd_valid && crd_vc_id == i.
  - consume only: count − 1.
  - ret only: count + 1.
  - both: unchanged.
  - neither: unchanged.
- Overflow: ret only while count == BUFFER_DEPTH → count holds at BUFFER_DEPTH and crd_err is set.
- crd_valid with crd_vc_id ≥ NUM_VCS → no counter changes, crd_err is set.
- crd_err stays set until reset.
- Underflow cannot occur, because a VC with zero credits is never eligible.
- Reset mid-operation: any in-flight link flit is dropped (link_valid = 0) and all credits restore to BUFFER_DEPTH. Downstream must be reset together with this block.
- Invariant, checked by the bench: for each VC, credit_count + flits in flight + flits held in the downstream buffer == BUFFER_DEPTH.

Decomposition:
- coh_noc_pkg owns:
  - flit_u (existing);
  - NUM_VCS_DEFAULT = 4;
  - vc_id_t (logic [1:0]);
  - VC_REQ/VC_RSP/VC_DAT/VC_SNP localparams.
- Sub-module rr_arbiter #(N), instantiated with N = NUM_VCS:
  - inputs req[N-1:0] and advance;
  - output one-hot grant;
  - owns the priority pointer.
- Credit counters and the output register live in vc_credit_tx.

Test Plan:
- Reset, then in_valid = 4'b0000 → credit_count all 16, link_valid = 0, in_ready = 0, crd_err = 0.
- Hold in_valid = 4'b0001, no credit returns.
  - 16 consecutive grants follow, then in_ready[0] = 0.
  - credit_count[0] = 0 and exactly 16 link flits appear with link_vc_id = 0, each one cycle after its accept.
- Hold in_valid = 4'b1111 with credits available → grant order 0, 1, 2, 3, 0, 1, …; link_vc_id follows the same sequence one cycle later.
- VC2 at 0 credits with in_valid[2] = 1.
  - crd_valid = 1, crd_vc_id = 2 in cycle N → no grant in N, grant in N+1.
  - The count goes 0 → 1 → 0.
- VC1 at 5 credits; in the same cycle, grant VC1 and return a credit to VC1 → count stays 5.
- Return a credit on VC3 at count 16 → count stays 16 and crd_err = 1, which stays set until rst_n is pulsed low.
